// File: rtl/rgb_frame_streamer_pkg.sv
// RGB frame streamer shared types and constants.
// Imported by the streamer top, its FIFO and the bench.
package rgb_frame_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE,
    ST_WAIT
  } state_t;

  localparam int N_DEF   = 64;
  localparam int M_DEF   = 64;
  localparam int BPP_DEF = 3;

  localparam int FRAME_BYTES = N_DEF * M_DEF * BPP_DEF;

  localparam logic [1:0] PH_R = 2'd0;
  localparam logic [1:0] PH_G = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;

  function automatic int frame_bytes(
    input int n,
    input int m,
    input int bpp
  );
    return n * m * bpp;
  endfunction

endpackage

// File: rtl/rgb_frame_streamer_if.sv
// Byte stream to the grayscale stage.
// Valid / pause handshake.
interface rgb_frame_streamer_if;

  logic [7:0] dout;
  logic       dout_valid;
  logic [1:0] byte_phase;
  logic       last;
  logic       pause;

  modport master (
    output dout,
    output dout_valid,
    output byte_phase,
    output last,
    input  pause
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  byte_phase,
    input  last,
    output pause
  );

endinterface

// File: rtl/rgb_frame_streamer_byte_skid_fifo.sv
// Two-entry byte FIFO; the head entry drives the stream output.
// Flush empties it in one cycle.
module byte_skid_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [1:0] occ,
  output logic       empty
);

  logic [7:0] mem_q [2];
  logic       wp_q;
  logic       rp_q;
  logic [1:0] occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      occ_q    <= '0;
    end else if (flush) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      occ_q <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= din;
        wp_q        <= ~wp_q;
      end
      if (pop) begin
        rp_q <= ~rp_q;
      end
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem_q[rp_q];
  assign occ   = occ_q;
  assign empty = (occ_q == 2'd0);

endmodule

// File: rtl/rgb_frame_streamer.sv
// Walks a stored RGB frame out of a 1-cycle RAM as a byte stream.
// Credit-limited reads keep the 2-entry FIFO from overflowing.
module rgb_frame_streamer
  import rgb_frame_streamer_pkg::*;
#(
  parameter int N         = 64,
  parameter int M         = 64,
  parameter int BPP       = 3,
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  rgb_frame_streamer_if.master  bus,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  done
);

  localparam int FB_INT = frame_bytes(N, M, BPP);
  localparam logic [ADDR_W-1:0] FB      = ADDR_W'(FB_INT);
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_INT - 1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] rd_cnt_q;
  logic [ADDR_W-1:0] tx_cnt_q;
  logic [1:0]        ph_q;
  logic [1:0]        ph_nxt;
  logic              inflight_q;

  logic [1:0] occ;
  logic [7:0] head;
  logic       empty;
  logic       valid;

  logic       active;
  logic       abort;
  logic       xfer;
  logic       last_b;
  logic       rd_en;
  logic       push;
  logic       clr;
  logic [2:0] pending;

  byte_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push),
    .pop   (xfer),
    .din   (mem_rdata),
    .dout  (head),
    .occ   (occ),
    .empty (empty)
  );

  assign valid  = ~empty;
  assign active = (state_q == ST_STREAM) | (state_q == ST_DRAIN);
  assign abort  = active & ~enable;
  assign xfer   = valid & ~bus.pause;
  assign last_b = valid & (tx_cnt_q == FB_LAST);
  assign clr    = (state_q == ST_IDLE) | abort;

  // Bytes already owed to the FIFO once this cycle's pop is taken.
  assign pending = {1'b0, occ}
                 + {2'b0, inflight_q}
                 - {2'b0, xfer};

  assign rd_en = (state_q == ST_STREAM) & enable
               & (rd_cnt_q < FB) & (pending < 3'd2);

  assign push = inflight_q & ~abort;

  always_comb begin
    ph_nxt = PH_R;
    unique case (1'b1)
      ph_q == PH_R: ph_nxt = PH_G;
      ph_q == PH_G: ph_nxt = PH_B;
      default:      ph_nxt = PH_R;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (!enable)             state_d = ST_IDLE;
        else if (rd_cnt_q == FB) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!enable)            state_d = ST_IDLE;
        else if (xfer & last_b) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      ph_q       <= PH_R;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      if (clr) begin
        rd_cnt_q <= '0;
        tx_cnt_q <= '0;
        ph_q     <= PH_R;
      end else begin
        if (rd_en) rd_cnt_q <= rd_cnt_q + ONE;
        if (xfer) begin
          tx_cnt_q <= tx_cnt_q + ONE;
          ph_q     <= ph_nxt;
        end
      end
    end
  end

  assign mem_rd_en = rd_en;
  assign mem_addr  = BASE + rd_cnt_q;
  assign done      = (state_q == ST_DONE);

  assign bus.dout_valid = valid;
  assign bus.dout       = valid ? head : 8'h00;
  assign bus.byte_phase = valid ? ph_q : PH_R;
  assign bus.last       = last_b;

endmodule

// File: tb/tb_rgb_frame_streamer.sv
// Bench for rgb_frame_streamer: a 2x2 frame and a full 64x64 frame.
// Expected bytes come from the stored frame in raster order.
module tb_rgb_frame_streamer;

  localparam int SFB = 12;
  localparam int BFB = 64 * 64 * 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] en = 2'b00;
  logic [1:0] pz = 2'b00;

  rgb_frame_streamer_if s_if ();
  rgb_frame_streamer_if b_if ();

  logic        s_rd, b_rd, s_done, b_done;
  logic [3:0]  s_addr;
  logic [13:0] b_addr;
  logic [7:0]  s_rdata = 8'h00;
  logic [7:0]  b_rdata = 8'h00;
  logic [7:0]  s_ram [16];
  logic [7:0]  b_ram [16384];

  assign s_if.pause = pz[0];
  assign b_if.pause = pz[1];

  rgb_frame_streamer #(
    .N(2), .M(2), .BPP(3), .ADDR_W(4), .BASE_ADDR(0)
  ) u_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (en[0]),
    .bus       (s_if),
    .mem_rd_en (s_rd),
    .mem_addr  (s_addr),
    .mem_rdata (s_rdata),
    .done      (s_done)
  );

  rgb_frame_streamer #(
    .N(64), .M(64), .BPP(3), .ADDR_W(14), .BASE_ADDR(0)
  ) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (en[1]),
    .bus       (b_if),
    .mem_rd_en (b_rd),
    .mem_addr  (b_addr),
    .mem_rdata (b_rdata),
    .done      (b_done)
  );

  always @(posedge clk) if (s_rd) s_rdata <= s_ram[s_addr];
  always @(posedge clk) if (b_rd) b_rdata <= b_ram[b_addr];

  logic [1:0]  vld, lst, rde, dn;
  logic [7:0]  dq [2];
  logic [1:0]  ph [2];
  logic [13:0] ad [2];

  assign vld[0] = s_if.dout_valid;
  assign vld[1] = b_if.dout_valid;
  assign lst[0] = s_if.last;
  assign lst[1] = b_if.last;
  assign rde[0] = s_rd;
  assign rde[1] = b_rd;
  assign dn[0]  = s_done;
  assign dn[1]  = b_done;
  assign dq[0]  = s_if.dout;
  assign dq[1]  = b_if.dout;
  assign ph[0]  = s_if.byte_phase;
  assign ph[1]  = b_if.byte_phase;
  assign ad[0]  = {10'd0, s_addr};
  assign ad[1]  = b_addr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int d, input int k);
    if (d == 0) return 8'(16 + k);
    return b_ram[k];
  endfunction

  // Caller has just set enable at a falling edge. mode: 0 no pause,
  // 1 alternate, 2 random, 3 hold 10 cycles on the first byte.
  task automatic stream(input int d, input int mode,
                        input int stop_after, input int budget);
    int fb, cyc, got, issued, dones, hold, max_ad;
    int first_rd, first_v, first_x, last_x, done_cyc;
    bit p, pv_stall;
    logic [11:0] prev, cur;
    fb = (d == 0) ? SFB : BFB;
    cyc = 0; got = 0; issued = 0; dones = 0; hold = 0; max_ad = 0;
    first_rd = -1; first_v = -1; first_x = -1; last_x = -1;
    done_cyc = -1; pv_stall = 1'b0; prev = '0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      p = 1'b0;
      case (mode)
        1: p = (cyc % 2) == 1;
        2: p = ($urandom_range(1) == 1);
        3: if (vld[d] && got == 0 && hold < 10) begin
          p = 1'b1;
          hold++;
        end
        default: p = 1'b0;
      endcase
      pz[d] = p;
      #1;
      cur = {vld[d], lst[d], ph[d], dq[d]};
      if (pv_stall) chk("pause_stable", 32'(cur), 32'(prev));
      pv_stall = vld[d] && p;
      prev = cur;
      if (rde[d]) begin
        issued++;
        if (first_rd < 0) first_rd = cyc;
        if (int'(ad[d]) > max_ad) max_ad = int'(ad[d]);
      end
      if (dn[d]) begin
        dones++;
        done_cyc = cyc;
      end
      if (vld[d] && first_v < 0) first_v = cyc;
      if (!vld[d]) chk("quiet", 32'(cur[10:0]), 32'd0);
      if (mode == 3 && p) begin
        chk("hold_head", 32'(dq[d]), 32'h10);
        chk("hold_outstanding", 32'(issued - got <= 3), 32'd1);
      end
      if (vld[d] && !p) begin
        chk("xfer_extra", 32'(got < fb), 32'd1);
        if (got < fb) begin
          chk("byte", 32'(dq[d]), 32'(exp_byte(d, got)));
          chk("phase", 32'(ph[d]), 32'(got % 3));
          chk("last", 32'(lst[d]), 32'(got == fb - 1));
        end
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        got++;
        if (stop_after > 0 && got == stop_after) return;
      end
      if (got >= fb && cyc >= last_x + 3) break;
    end
    chk("frame_count", got, fb);
    chk("read_count", issued, fb);
    chk("addr_max", max_ad, fb - 1);
    chk("first_rd_cycle", first_rd, 1);
    chk("first_valid_cycle", first_v, 3);
    chk("done_once", dones, 1);
    chk("done_time", done_cyc, last_x + 1);
    if (mode == 0) chk("throughput", last_x - first_x, fb - 1);
    issued = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (rde[d]) issued++;
      if (dn[d]) dones++;
    end
    chk("wait_no_reads", issued, 0);
    chk("wait_no_done", dones, 1);
    chk("wait_quiet", 32'(vld[d]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) s_ram[i] = 8'(16 + i);
    for (int i = 0; i < 16384; i++) b_ram[i] = 8'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_small", 32'({s_if.dout, s_if.dout_valid, s_if.byte_phase,
        s_if.last, s_rd, s_addr, s_done}), 32'd0);
    chk("rst_big", 32'({b_if.dout, b_if.dout_valid, b_if.byte_phase,
        b_if.last, b_rd, b_addr, b_done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unpaused, alternating and held-pause frames
    for (int m = 0; m < 4; m++) begin
      if (m == 2) continue;
      @(negedge clk);
      en[0] = 1'b1;
      stream(0, m, 0, 200);
      @(negedge clk);
      en[0] = 1'b0;
      pz[0] = 1'b0;
    end

    // Abort after the 5th transfer, then restart
    @(negedge clk);
    en[0] = 1'b1;
    stream(0, 0, 5, 100);
    @(negedge clk);
    en[0] = 1'b0;
    pz[0] = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_valid", 32'(vld[0]), 32'd0);
    chk("abort_rd", 32'(rde[0]), 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", 32'(dn[0]), 32'd0);
    end
    @(negedge clk);
    en[0] = 1'b1;
    pz[0] = 1'b0;
    stream(0, 0, 0, 100);
    @(negedge clk);
    en[0] = 1'b0;

    // Reset while draining, then replay
    @(negedge clk);
    en[0] = 1'b1;
    stream(0, 0, 10, 100);
    @(negedge clk);
    pz[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("drain_state", 32'({vld[0], rde[0]}), 32'b10);
    rst_n = 1'b0;
    #1;
    chk("rst_drain", 32'({s_if.dout, s_if.dout_valid, s_if.byte_phase,
        s_if.last, s_rd, s_addr, s_done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pz[0] = 1'b0;
    stream(0, 0, 0, 100);
    @(negedge clk);
    en[0] = 1'b0;

    // Full 64x64 frame with random pause
    @(negedge clk);
    en[1] = 1'b1;
    stream(1, 2, 0, 40000);
    @(negedge clk);
    en[1] = 1'b0;
    pz[1] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
